// File: rtl/vram_arb_pkg.sv
// Shared types for the video RAM arbiter: read-return tags, CPU access states
// and the default RAM address width.
package vram_arb_pkg;

  localparam int ADDR_W_DEF = 15;

  // Marks which consumer owns the RAM read data returning next cycle.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_VID   = 2'd1,
    TAG_CPURD = 2'd2
  } tag_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_ISSUE = 2'd2,
    S_ACK   = 2'd3
  } cpu_state_e;

endpackage

// File: rtl/vram_arb_cpu_fsm.sv
// CPU side of the arbiter: pending access register, starvation counter and the
// IDLE/PEND/ISSUE/ACK sequencer that drives cpu_ack and cpu_wait_n.
module vram_arb_cpu_fsm
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WAIT_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              grant,
  output cpu_state_e        state,
  output logic              pend_we,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [7:0]        pend_wdata,
  output logic              wait_hit,
  output logic              cpu_ack,
  output logic              cpu_wait_n
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  cpu_state_e        state_q, state_d;
  logic              pend_v_q, pend_v_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_wdata_q, pend_wdata_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_wait_n_q, cpu_wait_n_d;

  always_comb begin
    state_d      = state_q;
    pend_v_d     = pend_v_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    cpu_ack_d    = 1'b0;
    cpu_wait_n_d = cpu_wait_n_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req && !pend_v_q) begin
          state_d      = S_PEND;
          pend_v_d     = 1'b1;
          pend_we_d    = cpu_we;
          pend_addr_d  = cpu_addr;
          pend_wdata_d = cpu_wdata;
          wait_cnt_d   = 8'd0;
          cpu_wait_n_d = 1'b0;
        end
      end
      S_PEND: begin
        if (grant) begin
          state_d = S_ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      // Reads and writes both spend this cycle here so ack latency is uniform.
      S_ISSUE: begin
        state_d      = S_ACK;
        cpu_ack_d    = 1'b1;
        cpu_wait_n_d = 1'b1;
      end
      S_ACK: begin
        state_d  = S_IDLE;
        pend_v_d = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        pend_v_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pend_v_q     <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= 8'h00;
      wait_cnt_q   <= 8'd0;
      cpu_ack_q    <= 1'b0;
      cpu_wait_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_v_q     <= pend_v_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_wait_n_q <= cpu_wait_n_d;
    end
  end

  assign state      = state_q;
  assign pend_we    = pend_we_q;
  assign pend_addr  = pend_addr_q;
  assign pend_wdata = pend_wdata_q;
  assign wait_hit   = pend_v_q && (state_q == S_PEND) && (wait_cnt_q == LIMIT);
  assign cpu_ack    = cpu_ack_q;
  assign cpu_wait_n = cpu_wait_n_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetches take priority, CPU accesses are
// queued and stalled via WAIT, with a starvation limit that forces a CPU slot.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WAIT_LIMIT = 8
) (
  input  logic              PIX_CLK,
  input  logic              RESET_N,
  input  logic              vid_rd,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_q,
  output logic [15:0]       force_cnt
);

  cpu_state_e        cpu_state;
  logic              pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [7:0]        pend_wdata;
  logic              wait_hit;

  logic              slot_forced;
  logic              slot_vid;
  logic              slot_cpu;
  logic              grant;

  tag_e              tag_q, tag_d;
  logic [7:0]        vid_data_q, vid_data_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [15:0]       force_cnt_q, force_cnt_d;

  vram_arb_cpu_fsm #(
    .ADDR_W     (ADDR_W),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_cpu_fsm (
    .clk        (PIX_CLK),
    .rst_n      (RESET_N),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .grant      (grant),
    .state      (cpu_state),
    .pend_we    (pend_we),
    .pend_addr  (pend_addr),
    .pend_wdata (pend_wdata),
    .wait_hit   (wait_hit),
    .cpu_ack    (cpu_ack),
    .cpu_wait_n (cpu_wait_n)
  );

  // A starved CPU request beats the display; otherwise the display always wins.
  always_comb begin
    slot_forced = wait_hit;
    slot_vid    = !wait_hit && vid_rd;
    slot_cpu    = !wait_hit && !vid_rd && (cpu_state == S_PEND);
    grant       = slot_forced || slot_cpu;
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (slot_vid) begin
      ram_addr = vid_addr;
    end else if (grant) begin
      ram_addr  = pend_addr;
      ram_we    = pend_we;
      ram_wdata = pend_wdata;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (slot_vid) begin
      tag_d = TAG_VID;
    end else if (grant && !pend_we) begin
      tag_d = TAG_CPURD;
    end

    vid_data_d  = (tag_q == TAG_VID)   ? ram_q : vid_data_q;
    cpu_rdata_d = (tag_q == TAG_CPURD) ? ram_q : cpu_rdata_q;

    force_cnt_d = force_cnt_q;
    if (slot_forced && (force_cnt_q != 16'hFFFF)) begin
      force_cnt_d = force_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge PIX_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tag_q       <= TAG_NONE;
      vid_data_q  <= 8'h00;
      cpu_rdata_q <= 8'h00;
      force_cnt_q <= 16'h0000;
    end else begin
      tag_q       <= tag_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      force_cnt_q <= force_cnt_d;
    end
  end

  assign vid_data  = vid_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign force_cnt = force_cnt_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, cycle-stamped reference model of the
// arbitration rules, directed scenarios and randomized traffic.
module tb_vram_arbiter;

  localparam int AW = 15;
  localparam int WL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vid_rd = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [7:0]    vid_data;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = 8'h00;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait_n;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_q = 8'h00;
  logic [15:0]   force_cnt;

  vram_arbiter #(.ADDR_W(AW), .WAIT_LIMIT(WL)) dut (
    .PIX_CLK    (clk),
    .RESET_N    (rst_n),
    .vid_rd     (vid_rd),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_wait_n (cpu_wait_n),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_q      (ram_q),
    .force_cnt  (force_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural RAM ----------------
  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    return (a == 15'h0100) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  logic [7:0] ram    [0:32767];
  bit         ram_wr [0:32767];
  int         we_cnt = 0;

  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr]    <= ram_wdata;
      ram_wr[ram_addr] <= 1'b1;
      we_cnt           <= we_cnt + 1;
    end
    ram_q <= ram_wr[ram_addr] ? ram[ram_addr] : init_byte(ram_addr);
  end

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         at;
    logic [7:0] val;
  } upd_t;

  upd_t          vid_q[$];
  upd_t          rd_q[$];
  logic [7:0]    ref_mem [0:32767];
  int            cyc;
  bit            m_waiting;
  int            m_wait;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  int            m_ack_cyc;
  logic [7:0]    m_vid;
  logic [7:0]    m_rd;
  logic [15:0]   m_fcnt;

  task automatic model_reset();
    m_waiting = 1'b0;
    m_wait    = 0;
    m_ack_cyc = -10;
    m_vid     = 8'h00;
    m_rd      = 8'h00;
    m_fcnt    = 16'h0000;
    vid_q.delete();
    rd_q.delete();
  endtask

  function automatic bit model_busy();
    return m_waiting || (cyc <= m_ack_cyc);
  endfunction

  // One clock cycle: predict this cycle's RAM slot, advance, then compare outputs.
  task automatic step();
    bit forced, vslot, cslot, load;
    forced = m_waiting && (m_wait == WL);
    vslot  = !forced && vid_rd;
    cslot  = !forced && !vslot && m_waiting;
    load   = cpu_req && !model_busy();
    #1;
    check_eq("ram_we", {31'd0, ram_we}, (forced || cslot) ? {31'd0, m_we} : 32'd0);
    check_eq("ram_addr", {17'd0, ram_addr},
             vslot ? {17'd0, vid_addr} : (forced || cslot) ? {17'd0, m_addr} : 32'd0);
    if ((forced || cslot) && m_we) check_eq("ram_wdata", {24'd0, ram_wdata}, {24'd0, m_wdata});
    if (vslot) vid_q.push_back('{cyc + 2, ref_mem[vid_addr]});
    if (forced || cslot) begin
      m_waiting = 1'b0;
      m_ack_cyc = cyc + 2;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else rd_q.push_back('{cyc + 2, ref_mem[m_addr]});
    end else if (m_waiting) begin
      m_wait++;
    end
    if (forced && m_fcnt != 16'hFFFF) m_fcnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (load) begin
      m_waiting = 1'b1;
      m_wait    = 0;
      m_we      = cpu_we;
      m_addr    = cpu_addr;
      m_wdata   = cpu_wdata;
    end
    while (vid_q.size() > 0 && vid_q[0].at <= cyc) begin
      m_vid = vid_q[0].val;
      void'(vid_q.pop_front());
    end
    while (rd_q.size() > 0 && rd_q[0].at <= cyc) begin
      m_rd = rd_q[0].val;
      void'(rd_q.pop_front());
    end
    check_eq("vid_data", {24'd0, vid_data}, {24'd0, m_vid});
    check_eq("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, m_rd});
    check_eq("cpu_ack", {31'd0, cpu_ack}, (cyc == m_ack_cyc) ? 32'd1 : 32'd0);
    check_eq("cpu_wait_n", {31'd0, cpu_wait_n},
             (m_waiting || cyc < m_ack_cyc) ? 32'd0 : 32'd1);
    check_eq("force_cnt", {16'd0, force_cnt}, {16'd0, m_fcnt});
    if (cyc == m_ack_cyc) cpu_req = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drain();
    cpu_req = 1'b0;
    vid_rd  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!model_busy()) break;
      step();
    end
  endtask

  task automatic cpu_access(input bit we, input logic [AW-1:0] addr,
                            input logic [7:0] data, output int lat);
    int start;
    drain();
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    start     = cyc;
    lat       = -1;
    for (int k = 0; k < 3 * WL + 20; k++) begin
      step();
      if (cpu_ack && lat < 0) lat = cyc - start;
      if (!cpu_req) break;
    end
    cpu_req = 1'b0;
  endtask

  task automatic drive_random(input int n, input int vid_pct);
    for (int k = 0; k < n; k++) begin
      vid_rd   = ($urandom_range(0, 99) < vid_pct);
      vid_addr = AW'(32'h0100 + $urandom_range(0, 15));
      if (!cpu_req && !model_busy() && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'(32'h0100 + $urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
      step();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, we0, f0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_byte(AW'(i));
    model_reset();

    // reset release with no traffic
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    check_eq("rst_vid_data", {24'd0, vid_data}, 32'd0);
    check_eq("rst_cpu_wait_n", {31'd0, cpu_wait_n}, 32'd1);
    check_eq("rst_force_cnt", {16'd0, force_cnt}, 32'd0);
    repeat (5) step();
    check_eq("idle_no_we", we_cnt, 0);

    // single display fetch of the preloaded byte, then hold
    vid_rd   = 1'b1;
    vid_addr = 15'h0100;
    step();
    vid_rd = 1'b0;
    step();
    check_eq("vid_a5", {24'd0, vid_data}, 32'hA5);
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("vid_hold", {24'd0, vid_data}, 32'hA5);
    end

    // uncontended CPU write then read
    we0 = we_cnt;
    cpu_access(1'b1, 15'h0200, 8'h3C, lat);
    check_eq("wr_latency", lat, 3);
    cpu_access(1'b0, 15'h0200, 8'h00, lat);
    check_eq("rd_latency", lat, 3);
    check_eq("rd_data", {24'd0, cpu_rdata}, 32'h3C);
    check_eq("one_we_cycle", we_cnt - we0, 1);

    // continuous display traffic starves a CPU read into a forced slot
    drain();
    f0       = force_cnt;
    vid_rd   = 1'b1;
    vid_addr = 15'h0105;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 15'h0200;
    lat      = -1;
    begin
      int start;
      start = cyc;
      for (int k = 0; k < 3 * WL + 20; k++) begin
        vid_addr = AW'(32'h0100 + (k % 16));
        step();
        if (cpu_ack && lat < 0) lat = cyc - start;
        if (!cpu_req) break;
      end
    end
    check_eq("forced_latency", lat, 3 + WL);
    check_eq("forced_cnt", force_cnt - f0, 1);
    check_eq("forced_rd_data", {24'd0, cpu_rdata}, 32'h3C);

    // alternating display fetches with CPU writes in the gaps
    drain();
    f0 = force_cnt;
    for (int k = 0; k < 40; k++) begin
      vid_rd   = k[0];
      vid_addr = AW'(32'h0300 + (k % 8));
      if (!cpu_req && !model_busy()) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = AW'(32'h0300 + $urandom_range(0, 7));
        cpu_wdata = 8'($urandom);
      end
      step();
    end
    check_eq("alt_no_force", force_cnt - f0, 0);

    // randomized traffic, light then heavy display load
    drive_random(1500, 30);
    drive_random(800, 95);

    // reset while a CPU write sits in PEND
    drain();
    we0       = we_cnt;
    vid_rd    = 1'b1;
    vid_addr  = 15'h0100;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 15'h0400;
    cpu_wdata = 8'h77;
    step();
    step();
    check_eq("pend_wait_n", {31'd0, cpu_wait_n}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_wait_n", {31'd0, cpu_wait_n}, 32'd1);
    check_eq("async_ram_we", {31'd0, ram_we}, 32'd0);
    vid_rd  = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hold_wait_n", {31'd0, cpu_wait_n}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc += 4;
    model_reset();
    check_eq("post_rst_force_cnt", {16'd0, force_cnt}, 32'd0);
    check_eq("post_rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    repeat (10) step();
    check_eq("rst_no_write", we_cnt - we0, 0);
    check_eq("rst_mem_intact", {24'd0, ram_wr[15'h0400] ? ram[15'h0400] : init_byte(15'h0400)},
             {24'd0, ref_mem[15'h0400]});

    // short random run after reset to confirm normal operation resumes
    drive_random(200, 50);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter that sits directly upstream of the MC6847 display pipeline. It serves the display's read-request/address/data port (RD, DA, DD) and the Z80 CPU's video-RAM window from one synchronous RAM. The display has priority. CPU accesses are queued and the CPU is stalled through its WAIT line until its access completes. A starvation limit bounds CPU stall time, and forced CPU slots are counted.

## Interface
- ADDR_W, 15: RAM address width. Covers 24 KB SSHRG space.
- WAIT_LIMIT, 8: maximum cycles a CPU request may be pending before it pre-empts video. Legal range 1..255.
- PIX_CLK  in  1: sole clock. All logic is on its rising edge.
- RESET_N  in  1: reset, asynchronous, active-low.
- vid_rd  in  1: display read request, one cycle per fetch (from RD).
- vid_addr  in  ADDR_W: display address (from DA), valid with vid_rd.
- vid_data  out  8: fetched byte to display (to DD). Held between fetches.
- cpu_req  in  1: CPU access request, level. Held until cpu_ack.
- cpu_we  in  1: 1 = write, 0 = read. Valid with cpu_req.
- cpu_addr  in  ADDR_W: CPU address.
- cpu_wdata  in  8: CPU write data.
- cpu_rdata  out  8: CPU read data. Valid in the cpu_ack cycle and held afterwards.
- cpu_ack  out  1: single-cycle completion pulse.
- cpu_wait_n  out  1: low while a CPU request is accepted and not yet acked.
- ram_addr  out  ADDR_W: RAM address, combinational mux.
- ram_we  out  1: RAM write strobe.
- ram_wdata  out  8: RAM write data.
- ram_q  in  8: RAM read data. Synchronous, 1-cycle latency.
- force_cnt  out  16: saturating count of forced CPU slots.

## Operation
- Pending register (pend_v, pend_we, pend_addr, pend_wdata) is loaded when cpu_req=1, pend_v=0, and no ack or completion is in progress. Data is captured at that edge.
- A wait counter clears on load and increments each cycle pend_v=1 without a grant.
- Slot decision per cycle:
  - Forced: pend_v & wait_cnt==WAIT_LIMIT. CPU slot. The video request that cycle is dropped and force_cnt increments. vid_data keeps its old value.
  - Video: otherwise, if vid_rd=1. Drives ram_addr=vid_addr, ram_we=0.
  - CPU: otherwise, if pend_v. Drives ram_addr=pend_addr, ram_we=pend_we, ram_wdata=pend_wdata.
  - Idle: otherwise. ram_addr=0, ram_we=0.
- Return tag register: records VID, CPU_RD or none for the slot just issued. Next cycle ram_q is steered by the tag: VID loads vid_data, CPU_RD loads cpu_rdata.
- CPU states:
  - IDLE: go to PEND on load.
  - PEND: go to ISSUE on grant.
  - ISSUE: go to ACK.
  - ACK: cpu_ack=1, pend_v cleared, then go to IDLE.
  - A write still passes through ISSUE, so its latency from grant is identical to a read's.
- New requests: a new request is accepted no earlier than the cycle after ACK. If cpu_req is still high then, it counts as a new access. The CPU bridge is responsible for dropping req on ack.
- Simultaneous vid_rd and CPU grant: video wins unless the grant is forced.
- force_cnt saturates at 16'hFFFF.

## Timing
- Reset values: vid_data=0, cpu_rdata=0, cpu_ack=0, cpu_wait_n=1, ram_we=0, ram_addr=0, force_cnt=0, pend_v=0, tag=none, state IDLE.
- Video latency: vid_rd sampled at edge N → ram_q valid in cycle N+1 → vid_data valid from edge N+2.
- CPU latency, no contention: cpu_req high at edge N (load), grant at N+1, ISSUE at N+2, cpu_ack high during cycle N+3.
  - cpu_wait_n goes low in the cycle after the load edge and returns high with cpu_ack.
- Worst-case CPU latency: 3 + WAIT_LIMIT cycles.
- Reset mid-operation: any pending access is discarded. A write that was already issued may have completed in RAM; the write is not retried.

## Structure
- vram_arb_pkg holds:
  - the tag enum (TAG_NONE, TAG_VID, TAG_CPURD);
  - the CPU state enum (S_IDLE, S_PEND, S_ISSUE, S_ACK);
  - the default ADDR_W.
- One sub-module, vram_arb_cpu_fsm, holds the pending register, wait counter and state machine. Slot mux, tag pipeline and output registers live at top level.

## Test plan
- Reset release, no traffic → all outputs at reset values. ram_we never asserts.
- RAM preloaded with 8'hA5 at 15'h0100; vid_rd pulse with vid_addr=15'h0100 at edge N → vid_data=8'hA5 from edge N+2. vid_data holds 8'hA5 through 10 idle cycles.
- CPU write 8'h3C to 15'h0200, then read 15'h0200, with no video traffic:
  - each access → cpu_ack in cycle N+3;
  - the read returns cpu_rdata=8'h3C;
  - exactly one ram_we cycle occurs.
- vid_rd held high continuously with a CPU read pending, WAIT_LIMIT=8 → grant forced after 8 waiting cycles, force_cnt=1, and that video fetch is dropped (vid_data unchanged).
- Alternating vid_rd with CPU writes → every video fetch is served on its own cycle, CPU writes land only in gaps, force_cnt stays 0.
- RESET_N asserted in PEND with cpu_wait_n=0 → cpu_wait_n=1 immediately (asynchronously), no ram_we, and the pending access is gone after release.
